// File: rtl/onehot_phase_monitor_if.sv
// Bundles the signals between the phase monitor and whatever feeds and observes it.
// The monitor itself is the slave side of this interface.
interface onehot_phase_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       phase_in;
  logic             err_clr;
  logic [1:0]       phase_idx;
  logic             phase_valid;
  logic             rot_pulse;
  logic [CNT_W-1:0] rot_count;
  logic             locked;
  logic             err_onehot;
  logic             err_order;

  modport master (
    output phase_in, err_clr,
    input  phase_idx, phase_valid, rot_pulse, rot_count, locked, err_onehot, err_order
  );

  modport slave (
    input  phase_in, err_clr,
    output phase_idx, phase_valid, rot_pulse, rot_count, locked, err_onehot, err_order
  );
endinterface

// File: rtl/onehot_phase_monitor.sv
// Watches a 3-phase one-hot rotation, decodes it, flags illegal samples and declares lock.
// Define PHASE_MON_HOLD_EN to accept a repeated phase as a legal stall.
module onehot_phase_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_ROT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  onehot_phase_monitor_if.slave  mon
);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [2:0]       prev_reg;
  logic [7:0]       good_rot_reg;
  logic [1:0]       phase_idx_reg;
  logic             phase_valid_reg;
  logic             rot_pulse_reg;
  logic [CNT_W-1:0] rot_count_reg;
  logic             locked_reg;
  logic             err_onehot_reg;
  logic             err_order_reg;

  logic [2:0] sample;
  logic [1:0] idx_term [3];
  logic [1:0] sample_idx;
  logic       sample_onehot;
  logic       is_succ;
  logic       is_wrap;
  logic       is_hold;
  logic       rot_event;
  logic [7:0] good_rot_inc;

  assign sample = mon.phase_in;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_idx
      assign idx_term[gi] = sample[gi] ? 2'(gi) : 2'd0;
    end
  endgenerate

  assign sample_idx    = idx_term[0] | idx_term[1] | idx_term[2];
  assign sample_onehot = (sample != 3'b000) && ((sample & (sample - 3'd1)) == 3'b000);
  // Legal successor is a left rotation of the previous phase.
  assign is_succ       = (sample == {prev_reg[1:0], prev_reg[2]});
  assign is_wrap       = is_succ && (prev_reg == 3'b100);
`ifdef PHASE_MON_HOLD_EN
  assign is_hold       = (sample == prev_reg);
`else
  assign is_hold       = 1'b0;
`endif
  assign rot_event     = (state_reg != IDLE) && sample_onehot && is_wrap;
  assign good_rot_inc  = good_rot_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      prev_reg        <= 3'b000;
      good_rot_reg    <= 8'd0;
      phase_idx_reg   <= 2'd0;
      phase_valid_reg <= 1'b0;
      rot_pulse_reg   <= 1'b0;
      rot_count_reg   <= '0;
      locked_reg      <= 1'b0;
      err_onehot_reg  <= 1'b0;
      err_order_reg   <= 1'b0;
    end else begin
      phase_valid_reg <= sample_onehot;
      phase_idx_reg   <= sample_onehot ? sample_idx : 2'd0;
      rot_pulse_reg   <= rot_event;

      // Clear first; any error set below in the same cycle overrides it.
      if (mon.err_clr) begin
        err_onehot_reg <= 1'b0;
        err_order_reg  <= 1'b0;
        rot_count_reg  <= rot_event ? CNT_W'(1) : '0;
      end else if (rot_event && (rot_count_reg != CNT_MAX)) begin
        rot_count_reg  <= rot_count_reg + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (sample_onehot) begin
            state_reg    <= TRACK;
            prev_reg     <= sample;
            good_rot_reg <= 8'd0;
          end else begin
            err_onehot_reg <= 1'b1;
          end
        end
        TRACK, LOCKED: begin
          if (!sample_onehot) begin
            err_onehot_reg <= 1'b1;
            state_reg      <= IDLE;
            locked_reg     <= 1'b0;
          end else if (is_hold) begin
            state_reg <= state_reg;
          end else if (is_succ) begin
            prev_reg <= sample;
            if (is_wrap && (state_reg == TRACK)) begin
              good_rot_reg <= good_rot_inc;
              if (good_rot_inc == 8'(LOCK_ROT)) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end
          end else begin
            // Resync on the offending sample and restart the clean run.
            err_order_reg <= 1'b1;
            good_rot_reg  <= 8'd0;
            prev_reg      <= sample;
            state_reg     <= TRACK;
            locked_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mon.phase_idx   = phase_idx_reg;
  assign mon.phase_valid = phase_valid_reg;
  assign mon.rot_pulse   = rot_pulse_reg;
  assign mon.rot_count   = rot_count_reg;
  assign mon.locked      = locked_reg;
  assign mon.err_onehot  = err_onehot_reg;
  assign mon.err_order   = err_order_reg;
endmodule
